// File: rtl/spdif_frame_receiver.sv
// S/PDIF subframe receiver: hunts Z/X/Y preambles, biphase-mark decodes the 28
// data slots, checks parity and preamble order, and tracks block position and lock.
module spdif_frame_receiver #(
    parameter int LOCK_SUBFRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic        din_valid,
    output logic [19:0] dout,
    output logic [3:0]  aux,
    output logic        v_bit,
    output logic        u_bit,
    output logic        c_bit,
    output logic        channel,
    output logic        block_start,
    output logic [7:0]  frame_index,
    output logic        parity_ok,
    output logic        out_valid,
    output logic        err,
    output logic        locked
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_SUBFRAMES);

    typedef enum logic [1:0] {HUNT, DATA, PRE} state_t;
    typedef enum logic [1:0] {PRE_NONE, PRE_Z, PRE_X, PRE_Y} pre_t;

    // Oldest UI sits in bit 7; both line polarities map to the same preamble.
    function automatic pre_t classify(input logic [7:0] p);
        case (p)
            8'b1110_1000, 8'b0001_0111: return PRE_Z;
            8'b1110_0010, 8'b0001_1101: return PRE_X;
            8'b1110_0100, 8'b0001_1011: return PRE_Y;
            default:                    return PRE_NONE;
        endcase
    endfunction

    state_t      state, state_n;
    logic [7:0]  shreg, shreg_n, shifted;
    logic [5:0]  ui_cnt, ui_cnt_n;
    logic        prev_ui, prev_ui_n;
    logic [27:0] bits, bits_n;
    logic        cur_chan, cur_chan_n;
    logic        cur_z, cur_z_n;
    logic [7:0]  frame_cnt, frame_cnt_n;
    logic [3:0]  good_cnt, good_inc;
    pre_t        kind;
    logic        start_sub, emit, bmc_err, seq_err, parity_good;

    assign shifted     = {shreg[6:0], din};
    assign kind        = classify(shifted);
    assign good_inc    = (good_cnt == 4'd15) ? good_cnt : good_cnt + 4'd1;
    assign parity_good = ~^bits_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            shreg     <= '0;
            ui_cnt    <= '0;
            prev_ui   <= 1'b0;
            bits      <= '0;
            cur_chan  <= 1'b0;
            cur_z     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // register samples the values from before this edge.
            state     <= state_n;
            shreg     <= shreg_n;
            ui_cnt    <= ui_cnt_n;
            prev_ui   <= prev_ui_n;
            bits      <= bits_n;
            cur_chan  <= cur_chan_n;
            cur_z     <= cur_z_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_n     = state;
        shreg_n     = shreg;
        ui_cnt_n    = ui_cnt;
        prev_ui_n   = prev_ui;
        bits_n      = bits;
        cur_chan_n  = cur_chan;
        cur_z_n     = cur_z;
        frame_cnt_n = frame_cnt;
        start_sub   = 1'b0;
        emit        = 1'b0;
        bmc_err     = 1'b0;
        seq_err     = 1'b0;

        if (din_valid) begin
            case (state)
                HUNT: begin
                    shreg_n   = shifted;
                    start_sub = (kind != PRE_NONE);
                end
                DATA: begin
                    prev_ui_n = din;
                    if (!ui_cnt[0]) begin
                        bmc_err = (din == prev_ui);
                    end else begin
                        bits_n[ui_cnt[5:1]] = prev_ui ^ din;
                    end
                    if (bmc_err) begin
                        state_n = HUNT;
                        shreg_n = '0;
                    end else if (ui_cnt == 6'd55) begin
                        emit     = 1'b1;
                        state_n  = PRE;
                        ui_cnt_n = '0;
                    end else begin
                        ui_cnt_n = ui_cnt + 6'd1;
                    end
                end
                PRE: begin
                    shreg_n = shifted;
                    if (ui_cnt == 6'd7) begin
                        // Channel A must be followed by Y; Y by X or Z.
                        if (cur_chan ? (kind == PRE_X || kind == PRE_Z) : (kind == PRE_Y)) begin
                            start_sub = 1'b1;
                        end else begin
                            seq_err = 1'b1;
                            state_n = HUNT;
                        end
                    end else begin
                        ui_cnt_n = ui_cnt + 6'd1;
                    end
                end
                default: state_n = HUNT;
            endcase
        end

        if (start_sub) begin
            state_n    = DATA;
            ui_cnt_n   = '0;
            prev_ui_n  = din;
            bits_n     = '0;
            cur_chan_n = (kind == PRE_Y);
            cur_z_n    = (kind == PRE_Z);
            case (kind)
                PRE_Z:   frame_cnt_n = '0;
                PRE_X:   frame_cnt_n = (frame_cnt == 8'd191) ? 8'd0 : frame_cnt + 8'd1;
                default: frame_cnt_n = frame_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout        <= '0;
            aux         <= '0;
            v_bit       <= 1'b0;
            u_bit       <= 1'b0;
            c_bit       <= 1'b0;
            channel     <= 1'b0;
            block_start <= 1'b0;
            frame_index <= '0;
            parity_ok   <= 1'b0;
            out_valid   <= 1'b0;
            err         <= 1'b0;
            locked      <= 1'b0;
            good_cnt    <= '0;
        end else begin
            out_valid <= emit;
            err       <= bmc_err | seq_err;
            if (emit) begin
                dout        <= bits_n[23:4];
                aux         <= bits_n[3:0];
                v_bit       <= bits_n[24];
                u_bit       <= bits_n[25];
                c_bit       <= bits_n[26];
                channel     <= cur_chan;
                block_start <= cur_z;
                frame_index <= frame_cnt;
                parity_ok   <= parity_good;
                if (parity_good) begin
                    good_cnt <= good_inc;
                    locked   <= (good_inc >= LOCK_N);
                end else begin
                    good_cnt <= '0;
                    locked   <= 1'b0;
                end
            end else if (bmc_err || seq_err) begin
                good_cnt <= '0;
                locked   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spdif_frame_receiver.sv
// Directed bench for spdif_frame_receiver: BMC-encodes subframes with known
// fields and compares every strobed subframe against hand-built expectations.
module tb_spdif_frame_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic [19:0] dout;
    logic [3:0]  aux;
    logic        v_bit, u_bit, c_bit, channel, block_start;
    logic [7:0]  frame_index;
    logic        parity_ok, out_valid, err, locked;
    logic [40:0] out_all;

    always #5 clk = ~clk;

    spdif_frame_receiver #(.LOCK_SUBFRAMES(2)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .dout(dout), .aux(aux), .v_bit(v_bit), .u_bit(u_bit), .c_bit(c_bit),
        .channel(channel), .block_start(block_start), .frame_index(frame_index),
        .parity_ok(parity_ok), .out_valid(out_valid), .err(err), .locked(locked)
    );

    assign out_all = {dout, aux, v_bit, u_bit, c_bit, channel, block_start,
                      frame_index, parity_ok, out_valid, err, locked};

    typedef enum int {K_Z, K_X, K_Y} kind_t;
    typedef struct packed {
        logic [19:0] dout;
        logic [3:0]  aux;
        logic        v;
        logic        u;
        logic        c;
        logic        chan;
        logic        bs;
        logic [7:0]  fi;
        logic        pok;
        logic        lock;
    } rec_t;

    rec_t cap_q[$];
    int   err_cnt  = 0;
    int   ovl_cnt  = 0;
    int   n_checks = 0;
    int   n_fails  = 0;
    logic line_ui  = 1'b0;
    int   gap_max  = 0;

    always @(negedge clk) begin
        if (out_valid) cap_q.push_back({dout, aux, v_bit, u_bit, c_bit, channel,
                                        block_start, frame_index, parity_ok, locked});
        if (err) err_cnt = err_cnt + 1;
        if (out_valid && err) ovl_cnt = ovl_cnt + 1;
    end

    function automatic rec_t mk(input logic [19:0] d, input logic [3:0] a,
                                input logic v, input logic u, input logic c,
                                input logic ch, input logic bs, input logic [7:0] fi,
                                input logic pok, input logic lk);
        return {d, a, v, u, c, ch, bs, fi, pok, lk};
    endfunction

    function automatic logic [7:0] pre_pat(input kind_t k);
        case (k)
            K_Z:     return 8'b1110_1000;
            K_X:     return 8'b1110_0010;
            default: return 8'b1110_0100;
        endcase
    endfunction

    function automatic logic [27:0] pack_bits(input logic [19:0] d, input logic [3:0] a,
                                              input logic v, input logic u, input logic c,
                                              input logic bad_par);
        logic [27:0] b;
        b     = {1'b0, c, u, v, d, a};
        b[27] = (^b[26:0]) ^ bad_par;
        return b;
    endfunction

    task automatic send_ui(input logic b);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin
            @(negedge clk);
            din_valid = 1'b0;
        end
        @(negedge clk);
        din       = b;
        din_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    task automatic send_prefix(input logic first);
        repeat (8) send_ui(first);
        line_ui = ~first;
    endtask

    // Preamble polarity follows the line: its first UI differs from the last one sent.
    task automatic send_preamble(input kind_t k);
        logic [7:0] p;
        p = pre_pat(k);
        if (line_ui) p = ~p;
        for (int i = 7; i >= 0; i--) send_ui(p[i]);
        line_ui = p[0];
    endtask

    task automatic send_cells(input logic [27:0] b, input int corrupt, input int n_ui);
        logic prev, f, s;
        int   n;
        n    = 0;
        prev = line_ui;
        for (int k = 0; k < 28; k++) begin
            f = (k == corrupt) ? prev : ~prev;
            s = b[k] ? ~f : f;
            if (n < n_ui) begin send_ui(f); line_ui = f; n++; end
            if (n < n_ui) begin send_ui(s); line_ui = s; n++; end
            prev = s;
        end
    endtask

    task automatic send_sub(input kind_t k, input logic [19:0] d, input logic [3:0] a,
                            input logic v, input logic u, input logic c,
                            input logic bad_par, input int corrupt);
        send_preamble(k);
        send_cells(pack_bits(d, a, v, u, c, bad_par), corrupt, 56);
    endtask

    task automatic take(output rec_t r);
        if (cap_q.size() > 0) r = cap_q.pop_front();
        else r = 'x;
    endtask

    task automatic do_reset;
        din_valid = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        line_ui = 1'b0;
        gap_max = 0;
        cap_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_all !== 41'b0) begin
            n_fails++; $display("FAIL reset_outputs: got %h, expected 0", out_all);
        end
        rst = 1'b0;
        idle(3);
        n_checks++;
        if (out_all !== 41'b0) begin
            n_fails++; $display("FAIL idle_after_reset: got %h, expected 0", out_all);
        end
        n_checks++;
        if (cap_q.size() !== 0) begin
            n_fails++; $display("FAIL reset_no_strobe: got %0d strobes, expected 0", cap_q.size());
        end
    endtask

    task automatic test_normal_pair;
        rec_t got, exp;
        int   e0;
        do_reset;
        e0 = err_cnt;
        send_prefix(1'b1);
        send_sub(K_Z, 20'hA5A5A, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        send_sub(K_Y, 20'h0F0F0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        idle(3);
        take(got); exp = mk(20'hA5A5A, 4'h3, 0, 1, 1, 0, 1, 8'd0, 1, 0);
        n_checks++;
        if (got !== exp) begin n_fails++; $display("FAIL pair_z: got %h, expected %h", got, exp); end
        take(got); exp = mk(20'h0F0F0, 4'h5, 1, 0, 0, 1, 0, 8'd0, 1, 1);
        n_checks++;
        if (got !== exp) begin n_fails++; $display("FAIL pair_y: got %h, expected %h", got, exp); end
        n_checks++;
        if (err_cnt - e0 !== 0) begin n_fails++; $display("FAIL pair_err: got %0d, expected 0", err_cnt - e0); end
    endtask

    task automatic test_bmc_violation;
        rec_t got, exp;
        int   e0;
        e0 = err_cnt;
        send_sub(K_X, 20'h12345, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, 12);
        n_checks++;
        if (err_cnt - e0 !== 1) begin n_fails++; $display("FAIL bmc_err: got %0d pulses, expected 1", err_cnt - e0); end
        n_checks++;
        if (locked !== 1'b0) begin n_fails++; $display("FAIL bmc_unlock: got %b, expected 0", locked); end
        n_checks++;
        if (cap_q.size() !== 0) begin n_fails++; $display("FAIL bmc_drop: got %0d strobes, expected 0", cap_q.size()); end
        send_sub(K_Y, 20'hCAFE1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        send_sub(K_X, 20'h13579, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        idle(3);
        take(got); exp = mk(20'hCAFE1, 4'h7, 0, 0, 1, 1, 0, 8'd1, 1, 0);
        n_checks++;
        if (got !== exp) begin n_fails++; $display("FAIL bmc_resync_y: got %h, expected %h", got, exp); end
        take(got); exp = mk(20'h13579, 4'h2, 1, 1, 0, 0, 0, 8'd2, 1, 1);
        n_checks++;
        if (got !== exp) begin n_fails++; $display("FAIL bmc_relock_x: got %h, expected %h", got, exp); end
    endtask

    task automatic test_parity;
        rec_t got, exp;
        int   e0;
        e0 = err_cnt;
        send_sub(K_Y, 20'h55555, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        send_sub(K_X, 20'hFFFFF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        send_sub(K_Y, 20'h00001, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(3);
        take(got); exp = mk(20'h55555, 4'h0, 0, 1, 0, 1, 0, 8'd2, 0, 0);
        n_checks++;
        if (got !== exp) begin n_fails++; $display("FAIL parity_bad: got %h, expected %h", got, exp); end
        take(got); exp = mk(20'hFFFFF, 4'hF, 1, 1, 1, 0, 0, 8'd3, 1, 0);
        n_checks++;
        if (got !== exp) begin n_fails++; $display("FAIL parity_next: got %h, expected %h", got, exp); end
        take(got); exp = mk(20'h00001, 4'h8, 0, 0, 0, 1, 0, 8'd3, 1, 1);
        n_checks++;
        if (got !== exp) begin n_fails++; $display("FAIL parity_relock: got %h, expected %h", got, exp); end
        n_checks++;
        if (err_cnt - e0 !== 0) begin n_fails++; $display("FAIL parity_err: got %0d, expected 0", err_cnt - e0); end
    endtask

    task automatic test_seq_error;
        rec_t got, exp;
        send_sub(K_X, 20'h2468A, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        send_preamble(K_X);
        @(negedge clk);
        din_valid = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin n_fails++; $display("FAIL seq_err_pulse: got %b, expected 1", err); end
        n_checks++;
        if (locked !== 1'b0) begin n_fails++; $display("FAIL seq_unlock: got %b, expected 0", locked); end
        send_cells(pack_bits(20'h77777, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0), -1, 56);
        send_sub(K_Y, 20'hBEEF0, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        send_sub(K_X, 20'h0ACE5, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        idle(3);
        take(got); exp = mk(20'h2468A, 4'h1, 0, 1, 0, 0, 0, 8'd4, 1, 1);
        n_checks++;
        if (got !== exp) begin n_fails++; $display("FAIL seq_before: got %h, expected %h", got, exp); end
        take(got); exp = mk(20'hBEEF0, 4'h6, 0, 0, 1, 1, 0, 8'd4, 1, 0);
        n_checks++;
        if (got !== exp) begin n_fails++; $display("FAIL seq_rehunt_y: got %h, expected %h", got, exp); end
        take(got); exp = mk(20'h0ACE5, 4'h3, 1, 0, 0, 0, 0, 8'd5, 1, 1);
        n_checks++;
        if (got !== exp) begin n_fails++; $display("FAIL seq_after_x: got %h, expected %h", got, exp); end
        n_checks++;
        if (cap_q.size() !== 0) begin n_fails++; $display("FAIL seq_extra: got %0d strobes, expected 0", cap_q.size()); end
    endtask

    task automatic test_block_wrap;
        rec_t        exp_q[$];
        rec_t        got;
        logic [19:0] a;
        logic [7:0]  fb;
        int          e0, idx;
        do_reset;
        e0 = err_cnt;
        send_prefix(1'b1);
        for (int f = 0; f <= 192; f++) begin
            fb = 8'(f % 192);
            a  = {fb, 12'hC3A} ^ {12'h000, fb};
            send_sub((fb == 8'd0) ? K_Z : K_X, a, fb[3:0], fb[0], fb[1], fb[2], 1'b0, -1);
            exp_q.push_back(mk(a, fb[3:0], fb[0], fb[1], fb[2], 0, (fb == 8'd0), fb, 1,
                               (exp_q.size() >= 1)));
            send_sub(K_Y, ~a, ~fb[3:0], 1'b1, 1'b0, 1'b1, 1'b0, -1);
            exp_q.push_back(mk(~a, ~fb[3:0], 1, 0, 1, 1, 0, fb, 1, 1));
        end
        idle(3);
        idx = 0;
        foreach (exp_q[i]) begin
            take(got);
            n_checks++;
            if (got !== exp_q[i]) begin
                n_fails++;
                $display("FAIL wrap[%0d]: got %h, expected %h", idx, got, exp_q[i]);
            end
            idx++;
        end
        n_checks++;
        if (err_cnt - e0 !== 0) begin n_fails++; $display("FAIL wrap_err: got %0d, expected 0", err_cnt - e0); end
    endtask

    task automatic test_robust;
        rec_t got, exp;
        do_reset;
        gap_max = 3;
        send_prefix(1'b0);
        send_sub(K_Z, 20'hA5A5A, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        send_sub(K_Y, 20'h0F0F0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        idle(3);
        take(got); exp = mk(20'hA5A5A, 4'h3, 0, 1, 1, 0, 1, 8'd0, 1, 0);
        n_checks++;
        if (got !== exp) begin n_fails++; $display("FAIL inv_gap_z: got %h, expected %h", got, exp); end
        take(got); exp = mk(20'h0F0F0, 4'h5, 1, 0, 0, 1, 0, 8'd0, 1, 1);
        n_checks++;
        if (got !== exp) begin n_fails++; $display("FAIL inv_gap_y: got %h, expected %h", got, exp); end
        gap_max = 0;
        send_preamble(K_X);
        send_cells(pack_bits(20'h98765, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0), -1, 30);
        @(negedge clk);
        din_valid = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(70);
        n_checks++;
        if (cap_q.size() !== 0) begin n_fails++; $display("FAIL midreset_strobe: got %0d, expected 0", cap_q.size()); end
        n_checks++;
        if (out_all !== 41'b0) begin n_fails++; $display("FAIL midreset_outputs: got %h, expected 0", out_all); end
        line_ui = 1'b0;
        send_prefix(1'b1);
        send_sub(K_Z, 20'h31415, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        idle(3);
        take(got); exp = mk(20'h31415, 4'hE, 1, 0, 0, 0, 1, 8'd0, 1, 0);
        n_checks++;
        if (got !== exp) begin n_fails++; $display("FAIL midreset_recover: got %h, expected %h", got, exp); end
    endtask

    initial begin
        test_reset;
        test_normal_pair;
        test_bmc_violation;
        test_parity;
        test_seq_error;
        test_block_wrap;
        test_robust;
        n_checks++;
        if (ovl_cnt !== 0) begin n_fails++; $display("FAIL err_valid_overlap: got %0d, expected 0", ovl_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
